// File: rtl/board_input_sync_if.sv
// Board-pin side of the input conditioner: raw button/switch inputs and their
// debounced levels and event pulses.
interface board_input_sync_if #(
    parameter int unsigned SW_WIDTH = 16
);
    logic                btn_i;
    logic [SW_WIDTH-1:0] sw_i;
    logic                btn_level_o;
    logic                irq_btn_o;
    logic [SW_WIDTH-1:0] sw_o;
    logic                sw_changed_o;

    modport master (
        output btn_i, sw_i,
        input  btn_level_o, irq_btn_o, sw_o, sw_changed_o
    );

    modport slave (
        input  btn_i, sw_i,
        output btn_level_o, irq_btn_o, sw_o, sw_changed_o
    );
endinterface

// File: rtl/board_input_sync.sv
// Synchronises and debounces the board push-button and slide switches, producing
// clean levels, a press interrupt pulse and a switch-change pulse.
module board_input_sync #(
    parameter int unsigned SW_WIDTH    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 500000
) (
    input  logic              clk_i,
    input  logic              arst_i,
    board_input_sync_if.slave pins
);
    localparam int unsigned N  = SW_WIDTH + 1;
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES - 1);

    // Channel 0 is the button; channels 1..SW_WIDTH are the switches.
    logic [N-1:0] raw;
    logic [N-1:0] s;
    logic [N-1:0] stable;
    logic [N-1:0] accept;

    assign raw = {pins.sw_i, pins.btn_i};

    for (genvar i = 0; i < N; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt_q;
        logic [CW-1:0]          cnt_d;
        logic                   stable_q;
        logic                   acc;

        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
            end
        end

        assign s[i] = sync_q[SYNC_STAGES-1];

        always_comb begin
            cnt_d = cnt_q;
            acc   = 1'b0;
            if (s[i] == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                cnt_d = '0;
                acc   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                if (acc) begin
                    stable_q <= s[i];
                end
            end
        end

        assign stable[i] = stable_q;
        assign accept[i] = acc;
    end

    logic irq_q;
    logic irq_d;
    logic sw_chg_q;
    logic sw_chg_d;

    // Pulses register on the same edge the stable value updates.
    assign irq_d    = accept[0] & s[0];
    assign sw_chg_d = |accept[N-1:1];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            irq_q    <= 1'b0;
            sw_chg_q <= 1'b0;
        end else begin
            irq_q    <= irq_d;
            sw_chg_q <= sw_chg_d;
        end
    end

    assign pins.btn_level_o  = stable[0];
    assign pins.sw_o         = stable[N-1:1];
    assign pins.irq_btn_o    = irq_q;
    assign pins.sw_changed_o = sw_chg_q;
endmodule

// File: tb/tb_board_input_sync.sv
// Directed bench for board_input_sync: expected pulses are queued when stimulus
// is driven and matched against the DUT pulses as they appear.
module tb_board_input_sync;
    localparam int unsigned SW  = 16;
    localparam int unsigned SS  = 2;
    localparam int unsigned DB  = 4;
    localparam int          LAT = SS + DB;

    typedef struct {
        int        cyc;
        logic [15:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic arst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  irq_exp[$];
    ev_t  sw_exp[$];

    board_input_sync_if #(.SW_WIDTH(SW)) pins ();

    board_input_sync #(
        .SW_WIDTH   (SW),
        .SYNC_STAGES(SS),
        .DB_CYCLES  (DB)
    ) dut (
        .clk_i (clk),
        .arst_i(arst),
        .pins  (pins)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_irq(input int t);
        ev_t e;
        e.cyc = t;
        e.val = 16'h1;
        irq_exp.push_back(e);
    endtask

    task automatic push_sw(input int t, input logic [15:0] v);
        ev_t e;
        e.cyc = t;
        e.val = v;
        sw_exp.push_back(e);
    endtask

    // Scoreboard: every pulse cycle must consume one queued expectation.
    always @(negedge clk) begin
        ev_t ei;
        ev_t es;
        if (pins.irq_btn_o) begin
            if (irq_exp.size() == 0) begin
                check("irq_unexpected", 32'(pins.irq_btn_o), 0);
            end else begin
                ei = irq_exp.pop_front();
                check("irq_cycle", cyc, ei.cyc);
                check("irq_level", 32'(pins.btn_level_o), 1);
            end
        end
        if (pins.sw_changed_o) begin
            if (sw_exp.size() == 0) begin
                check("swchg_unexpected", 32'(pins.sw_changed_o), 0);
            end else begin
                es = sw_exp.pop_front();
                check("swchg_cycle", cyc, es.cyc);
                check("swchg_value", 32'(pins.sw_o), 32'(es.val));
            end
        end
    end

    initial begin
        int c;
        int r;
        int pat[6];
        pat = '{1, 0, 1, 1, 0, 1};

        // Reset with inputs high
        arst        = 1'b1;
        pins.btn_i  = 1'b1;
        pins.sw_i   = 16'hFFFF;
        go(3);
        check("rst_btn_level", 32'(pins.btn_level_o), 0);
        check("rst_sw", 32'(pins.sw_o), 0);
        check("rst_irq", 32'(pins.irq_btn_o), 0);
        check("rst_swchg", 32'(pins.sw_changed_o), 0);
        c = cyc;
        arst = 1'b0;
        push_irq(c + LAT);
        push_sw(c + LAT, 16'hFFFF);
        wait_to(c + LAT - 1);
        check("s1_level_early", 32'(pins.btn_level_o), 0);
        check("s1_sw_early", 32'(pins.sw_o), 0);
        wait_to(c + LAT);
        check("s1_level", 32'(pins.btn_level_o), 1);
        check("s1_sw", 32'(pins.sw_o), 32'hFFFF);
        go(3);
        c = cyc;
        pins.btn_i = 1'b0;
        pins.sw_i  = 16'h0000;
        push_sw(c + LAT, 16'h0000);
        wait_to(c + LAT + 4);
        check("s1_release_level", 32'(pins.btn_level_o), 0);

        // Short glitch (3 cycles) rejected
        pins.btn_i = 1'b1;
        go(3);
        pins.btn_i = 1'b0;
        go(12);
        check("glitch3_level", 32'(pins.btn_level_o), 0);

        // Exactly DB_CYCLES high accepted
        c = cyc;
        pins.btn_i = 1'b1;
        push_irq(c + LAT);
        go(4);
        pins.btn_i = 1'b0;
        wait_to(c + LAT);
        check("glitch4_level", 32'(pins.btn_level_o), 1);
        go(10);
        check("glitch4_fall", 32'(pins.btn_level_o), 0);

        // Clean press and release
        c = cyc;
        pins.btn_i = 1'b1;
        push_irq(c + LAT);
        wait_to(c + LAT - 1);
        check("press_early", 32'(pins.btn_level_o), 0);
        wait_to(c + LAT);
        check("press_level", 32'(pins.btn_level_o), 1);
        wait_to(c + 20);
        r = cyc;
        pins.btn_i = 1'b0;
        wait_to(r + LAT - 1);
        check("release_early", 32'(pins.btn_level_o), 1);
        wait_to(r + LAT);
        check("release_level", 32'(pins.btn_level_o), 0);
        go(4);

        // Bounce: final run of 1s starts at raw edge 6, accepted on edge 11
        c = cyc;
        push_irq(c + 11);
        for (int k = 0; k < 6; k++) begin
            pins.btn_i = pat[k][0];
            go(1);
        end
        wait_to(c + 10);
        check("bounce_early", 32'(pins.btn_level_o), 0);
        wait_to(c + 11);
        check("bounce_level", 32'(pins.btn_level_o), 1);
        go(3);
        pins.btn_i = 1'b0;
        go(10);

        // Independent switches
        c = cyc;
        pins.sw_i = 16'h0001;
        push_sw(c + LAT, 16'h0001);
        go(2);
        pins.sw_i = 16'h8001;
        push_sw(c + LAT + 2, 16'h8001);
        wait_to(c + LAT - 1);
        check("sw_early", 32'(pins.sw_o), 0);
        wait_to(c + LAT + 1);
        check("sw_bit0", 32'(pins.sw_o), 32'h0001);
        wait_to(c + LAT + 2);
        check("sw_bit15", 32'(pins.sw_o), 32'h8001);
        go(4);
        c = cyc;
        pins.sw_i = 16'h0000;
        push_sw(c + LAT, 16'h0000);
        go(10);
        c = cyc;
        pins.sw_i = 16'h0180;
        push_sw(c + LAT, 16'h0180);
        wait_to(c + LAT);
        check("sw_together", 32'(pins.sw_o), 32'h0180);
        go(4);
        c = cyc;
        pins.sw_i = 16'h0000;
        push_sw(c + LAT, 16'h0000);
        go(10);

        // Reset mid-count: one-cycle reset covering edge 4
        c = cyc;
        pins.btn_i = 1'b1;
        wait_to(c + 3);
        #2 arst = 1'b1;
        #1 check("midrst_irq", 32'(pins.irq_btn_o), 0);
        wait_to(c + 4);
        arst = 1'b0;
        push_irq(c + 4 + LAT);
        wait_to(c + 4 + LAT - 1);
        check("midrst_early", 32'(pins.btn_level_o), 0);
        wait_to(c + 4 + LAT);
        check("midrst_level", 32'(pins.btn_level_o), 1);
        go(3);

        // Asynchronous reset clears a settled level with no clock edge
        #2 arst = 1'b1;
        #1 check("async_rst_level", 32'(pins.btn_level_o), 0);
        go(1);
        arst = 1'b0;
        c = cyc;
        push_irq(c + LAT);
        wait_to(c + LAT);
        check("async_rst_relock", 32'(pins.btn_level_o), 1);
        go(2);
        pins.btn_i = 1'b0;
        go(10);
        check("final_level", 32'(pins.btn_level_o), 0);

        check("irq_queue_empty", irq_exp.size(), 0);
        check("sw_queue_empty", sw_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
